// File: rtl/branch_resolve_if.sv
// Branch request / redirect bundle between issue, the branch resolver and fetch.
// Signal names keep their direction prefixes as seen from the resolver.
interface branch_resolve_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  in_valid;
  logic                  out_ready;
  logic [2:0]            in_funct3;
  logic [4:0]            in_flag;
  logic [DATA_WIDTH-1:0] in_pc;
  logic [DATA_WIDTH-1:0] in_imm;
  logic                  out_resolved;
  logic                  out_taken;
  logic                  out_redirect_valid;
  logic                  in_redirect_ready;
  logic [DATA_WIDTH-1:0] out_target;
  logic                  out_flush;
  logic                  out_illegal;
  logic                  out_misalign;
  logic [31:0]           out_taken_cnt;

  modport master (
    output in_valid, in_funct3, in_flag, in_pc, in_imm, in_redirect_ready,
    input  out_ready, out_resolved, out_taken, out_redirect_valid, out_target,
           out_flush, out_illegal, out_misalign, out_taken_cnt
  );

  modport slave (
    input  in_valid, in_funct3, in_flag, in_pc, in_imm, in_redirect_ready,
    output out_ready, out_resolved, out_taken, out_redirect_valid, out_target,
           out_flush, out_illegal, out_misalign, out_taken_cnt
  );
endinterface

// File: rtl/branch_resolve.sv
// Branch resolver: captures one request, decides taken/not-taken from comparator
// flags, issues a redirect to fetch and holds a pipeline flush afterwards.
module branch_resolve #(
  parameter int DATA_WIDTH   = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input logic             in_clk,
  input logic             in_rst_n,
  branch_resolve_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RESOLVE, REDIRECT, FLUSH} state_t;

  typedef struct packed {
    logic [2:0]            funct3;
    logic [4:0]            flag;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] imm;
  } req_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t                state_q, state_d;
  req_t                  req_q;
  logic [3:0]            flush_q, flush_d;
  logic [31:0]           taken_cnt_q;
  logic [DATA_WIDTH-1:0] target;
  logic                  cond, illegal, taken, misalign;
  logic                  accept, redir_hs, in_resolve;

  // Adder wraps modulo 2^DATA_WIDTH; operands stay registered so the target is
  // stable for the whole redirect handshake.
  assign target = req_q.pc + req_q.imm;

  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (req_q.funct3)
      3'b000:  cond = req_q.flag[4];
      3'b001:  cond = ~req_q.flag[4];
      3'b100:  cond = req_q.flag[3];
      3'b101:  cond = req_q.flag[1];
      3'b110:  cond = req_q.flag[2];
      3'b111:  cond = req_q.flag[0];
      default: illegal = 1'b1;
    endcase
  end

  assign taken      = cond & ~illegal;
  assign misalign   = taken & (target[1:0] != 2'b00);
  assign in_resolve = (state_q == RESOLVE);
  assign accept     = bus.in_valid & (state_q == IDLE);
  assign redir_hs   = (state_q == REDIRECT) & bus.in_redirect_ready;

  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    case (state_q)
      IDLE:     if (accept) state_d = RESOLVE;
      RESOLVE:  state_d = (taken & ~misalign) ? REDIRECT : IDLE;
      REDIRECT: if (bus.in_redirect_ready) begin
                  state_d = FLUSH;
                  flush_d = FLUSH_LOAD;
                end
      FLUSH:    if (flush_q <= 4'd1) begin
                  state_d = IDLE;
                  flush_d = 4'd0;
                end else begin
                  flush_d = flush_q - 4'd1;
                end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q     <= IDLE;
      flush_q     <= 4'd0;
      req_q       <= '0;
      taken_cnt_q <= 32'd0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      if (accept) begin
        req_q.funct3 <= bus.in_funct3;
        req_q.flag   <= bus.in_flag;
        req_q.pc     <= bus.in_pc;
        req_q.imm    <= bus.in_imm;
      end
      if (redir_hs && taken_cnt_q != 32'hFFFF_FFFF)
        taken_cnt_q <= taken_cnt_q + 32'd1;
    end
  end

  assign bus.out_ready          = (state_q == IDLE);
  assign bus.out_resolved       = in_resolve;
  assign bus.out_taken          = in_resolve & taken;
  assign bus.out_illegal        = in_resolve & illegal;
  assign bus.out_misalign       = in_resolve & misalign;
  assign bus.out_redirect_valid = (state_q == REDIRECT);
  assign bus.out_target         = (state_q == REDIRECT) ? target : '0;
  assign bus.out_flush          = (state_q == FLUSH);
  assign bus.out_taken_cnt      = taken_cnt_q;
endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed corner cases plus random
// branches, each derived from real operand pairs and judged by a transaction model.
module tb_branch_resolve;
  localparam int DW = 64;
  localparam int FC = 2;

  logic in_clk   = 1'b0;
  logic in_rst_n = 1'b0;

  branch_resolve_if #(.DATA_WIDTH(DW)) bus ();

  branch_resolve #(.DATA_WIDTH(DW), .FLUSH_CYCLES(FC)) dut (
    .in_clk  (in_clk),
    .in_rst_n(in_rst_n),
    .bus     (bus.slave)
  );

  always #5 in_clk = ~in_clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_cnt = 32'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(negedge in_clk);
  endtask

  function automatic logic [4:0] flags_of(input logic [63:0] a, input logic [63:0] b);
    return {a == b, $signed(a) < $signed(b), a < b, $signed(a) >= $signed(b), a >= b};
  endfunction

  task automatic scramble;
    bus.in_valid  = 1'b0;
    bus.in_funct3 = 3'($urandom);
    bus.in_flag   = 5'($urandom);
    bus.in_pc     = {$urandom, $urandom};
    bus.in_imm    = {$urandom, $urandom};
  endtask

  // One branch from accept to return-to-idle; abort pulls reset in flush cycle 1.
  task automatic run_br(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] pc, input logic [63:0] imm,
                        input int wait_cyc, input bit abort);
    bit          ill, tk, mis, redir;
    logic [63:0] tgt;
    ill = (f3 == 3'd2) || (f3 == 3'd3);
    case (f3)
      3'd0:    tk = (a == b);
      3'd1:    tk = (a != b);
      3'd4:    tk = ($signed(a) < $signed(b));
      3'd5:    tk = ($signed(a) >= $signed(b));
      3'd6:    tk = (a < b);
      3'd7:    tk = (a >= b);
      default: tk = 1'b0;
    endcase
    tgt   = pc + imm;
    mis   = tk && (tgt[1:0] != 2'b00);
    redir = tk && !mis;

    chk("ready_idle", bus.out_ready, 1);
    bus.in_valid          = 1'b1;
    bus.in_funct3         = f3;
    bus.in_flag           = flags_of(a, b);
    bus.in_pc             = pc;
    bus.in_imm            = imm;
    bus.in_redirect_ready = 1'($urandom);
    step;
    scramble;
    bus.in_redirect_ready = 1'($urandom);
    chk("resolved", bus.out_resolved, 1);
    chk("taken", bus.out_taken, tk);
    chk("illegal", bus.out_illegal, ill);
    chk("misalign", bus.out_misalign, mis);
    chk("ready_resolve", bus.out_ready, 0);
    chk("rv_resolve", bus.out_redirect_valid, 0);
    chk("flush_resolve", bus.out_flush, 0);

    if (redir) begin
      for (int w = 0; w <= wait_cyc; w++) begin
        step;
        chk("rv", bus.out_redirect_valid, 1);
        chk("target", bus.out_target, tgt);
        chk("ready_redir", bus.out_ready, 0);
        chk("resolved_redir", bus.out_resolved, 0);
        chk("cnt_redir", bus.out_taken_cnt, m_cnt);
        bus.in_redirect_ready = (w == wait_cyc);
      end
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      for (int f = 0; f < FC; f++) begin
        step;
        bus.in_redirect_ready = 1'($urandom);
        chk("flush", bus.out_flush, 1);
        chk("rv_flush", bus.out_redirect_valid, 0);
        chk("ready_flush", bus.out_ready, 0);
        chk("cnt_flush", bus.out_taken_cnt, m_cnt);
        if (abort && f == 0) begin
          in_rst_n = 1'b0;
          #1;
          m_cnt = 32'd0;
          chk("flush_rst", bus.out_flush, 0);
          chk("cnt_rst", bus.out_taken_cnt, m_cnt);
          chk("rv_rst", bus.out_redirect_valid, 0);
          step;
          in_rst_n = 1'b1;
          step;
          chk("ready_after_rst", bus.out_ready, 1);
          chk("flush_after_rst", bus.out_flush, 0);
          return;
        end
      end
    end
    step;
    chk("ready_back", bus.out_ready, 1);
    chk("flush_back", bus.out_flush, 0);
    chk("rv_back", bus.out_redirect_valid, 0);
    chk("resolved_back", bus.out_resolved, 0);
    chk("cnt_back", bus.out_taken_cnt, m_cnt);
  endtask

  initial begin
    logic [63:0] a, b, pc, imm;
    scramble;
    bus.in_redirect_ready = 1'b0;
    #2;
    chk("rst_resolved", bus.out_resolved, 0);
    chk("rst_taken", bus.out_taken, 0);
    chk("rst_rv", bus.out_redirect_valid, 0);
    chk("rst_target", bus.out_target, 0);
    chk("rst_flush", bus.out_flush, 0);
    chk("rst_illegal", bus.out_illegal, 0);
    chk("rst_misalign", bus.out_misalign, 0);
    chk("rst_cnt", bus.out_taken_cnt, 0);
    step;
    step;
    in_rst_n = 1'b1;

    run_br(3'd0, 64'd7, 64'd7, 64'h1000, 64'h20, 0, 0);
    chk("cnt_first", bus.out_taken_cnt, 1);
    run_br(3'd6, 64'd5, 64'd3, 64'h2000, 64'h10, 0, 0);
    run_br(3'd5, 64'd5, 64'd3, 64'h4, 64'hFFFF_FFFF_FFFF_FFF8, 5, 0);
    run_br(3'd2, 64'd1, 64'd1, 64'h1000, 64'h8, 0, 0);
    run_br(3'd3, 64'd1, 64'd2, 64'h1000, 64'h8, 0, 0);
    run_br(3'd1, 64'd1, 64'd2, 64'h1000, 64'h2, 0, 0);
    run_br(3'd0, 64'd9, 64'd9, 64'h2000, 64'h40, 1, 1);
    chk("cnt_after_abort", bus.out_taken_cnt, 0);
    run_br(3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h3000, 64'h100, 1, 0);

    for (int i = 0; i < 60; i++) begin
      a   = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 7));
      b   = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
      pc  = {$urandom, $urandom};
      imm = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) begin
        pc[1:0]  = 2'b00;
        imm[1:0] = 2'b00;
      end
      run_br(3'($urandom), a, b, pc, imm, $urandom_range(0, 3), 1'b0);
    end

    force dut.taken_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.taken_cnt_q;
    m_cnt = 32'hFFFF_FFFD;
    step;
    chk("cnt_preload", bus.out_taken_cnt, m_cnt);
    for (int i = 0; i < 4; i++)
      run_br(3'd7, 64'd8, 64'd2, 64'h100, 64'h40, i, 0);
    chk("cnt_saturated", bus.out_taken_cnt, 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
